// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MemOp codes, MMIO offsets and CON_STAT layout
//
// Purpose: constants shared by the data-memory responder and its bench-facing
// console FIFO. No ports.
package dmem_pkg;

  // MemOp encoding from the CPU; 011/110/111 are illegal.
  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } memop_e;

  // Word offsets inside the MMIO window (dmemaddr[3:2]).
  localparam logic [1:0] OFF_CYCLE    = 2'd0;
  localparam logic [1:0] OFF_TOHOST   = 2'd1;
  localparam logic [1:0] OFF_CON_TX   = 2'd2;
  localparam logic [1:0] OFF_CON_STAT = 2'd3;

  // CON_STAT read-back layout.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_MSB = 11;

endpackage

// File: rtl/con_fifo.sv
// rtl/con_fifo.sv - console TX byte FIFO drained by the bench
//
// Purpose: CON_DEPTH-entry byte FIFO. A push while full is accepted only if a
// pop happens in the same cycle; a pop while empty is a no-op.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   push_i, data_i   push request and byte
//   pop_i            pop request (ignored when empty)
//   data_o           head byte, meaningful only while !empty_o
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries (0..CON_DEPTH)
module con_fifo #(
  parameter int CON_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [7:0]                   data_i,
  input  logic                         pop_i,
  output logic [7:0]                   data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(CON_DEPTH):0]   count_o
);

  localparam int AW = $clog2(CON_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(CON_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [CON_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // When full, the slot being written is the head being popped this edge;
  // the head is read before the edge, so the overwrite is safe.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_mmio_resp.sv
// rtl/dmem_mmio_resp.sv - CPU data-memory responder: RAM, MMIO registers, console FIFO
//
// Purpose: slave end of the single-cycle CPU data bus. Byte-addressed RAM with
// lane steering and sign extension, plus an MMIO window (CYCLE, TOHOST,
// CON_TX, CON_STAT) so system benches can detect program completion.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   dmemaddr, dmemdatain             byte address and store data
//   dmemop, dmemwe                   MemOp and store enable
//   dmemdataout                      combinational load data
//   con_data, con_valid, con_ready   console FIFO head / non-empty / pop
//   halt, pass, err, con_overflow    sticky status flags
module dmem_mmio_resp
  import dmem_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          CON_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  output logic [31:0] dmemdataout,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        halt,
  output logic        pass,
  output logic        err,
  output logic        con_overflow
);

  localparam int CW = $clog2(CON_DEPTH) + 1;

  logic [31:0]       ram_q [2**RAM_AW];
  logic [31:0]       cycle_q, cycle_d, tohost_q, tohost_d;
  logic              halt_q, halt_d, pass_q, pass_d, err_q, err_d, ovf_q, ovf_d;

  logic              is_mmio, op_ok, op_half, op_word, op_uns, illegal;
  logic [1:0]        off;
  logic [RAM_AW-1:0] word_idx;
  logic [31:0]       ram_word, stat_word, rd_data, st_data;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [3:0]        st_be;
  logic              st_ok, ram_we, push_req, pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              unused_addr;

  assign is_mmio     = (dmemaddr[31:28] == MMIO_BASE[31:28]);
  assign off         = dmemaddr[3:2];
  assign word_idx    = dmemaddr[RAM_AW+1:2];
  assign unused_addr = ^dmemaddr[27:RAM_AW+2];

  always_comb begin
    op_ok   = 1'b1;
    op_half = 1'b0;
    op_word = 1'b0;
    op_uns  = 1'b0;
    case (dmemop)
      MOP_B:   ;
      MOP_H:   op_half = 1'b1;
      MOP_W:   op_word = 1'b1;
      MOP_BU:  op_uns  = 1'b1;
      MOP_HU:  begin op_half = 1'b1; op_uns = 1'b1; end
      default: op_ok   = 1'b0;
    endcase
  end

  // Zero-extending ops are load-only; MMIO registers are word-only.
  assign illegal = !op_ok
                || (op_half && dmemaddr[0])
                || (op_word && (dmemaddr[1:0] != 2'b00))
                || (dmemwe && op_uns)
                || (is_mmio && !op_word);

  // ---------------- loads ----------------
  assign ram_word = ram_q[word_idx];
  assign rd_half  = dmemaddr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    rd_byte = ram_word[7:0];
    case (dmemaddr[1:0])
      2'd1:    rd_byte = ram_word[15:8];
      2'd2:    rd_byte = ram_word[23:16];
      2'd3:    rd_byte = ram_word[31:24];
      default: rd_byte = ram_word[7:0];
    endcase
  end

  always_comb begin
    stat_word = '0;
    stat_word[STAT_FULL_BIT]  = fifo_full;
    stat_word[STAT_EMPTY_BIT] = fifo_empty;
    stat_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(fifo_cnt);
  end

  always_comb begin
    rd_data = '0;
    if (!illegal) begin
      if (is_mmio) begin
        case (off)
          OFF_CYCLE:  rd_data = cycle_q;
          OFF_TOHOST: rd_data = tohost_q;
          OFF_CON_TX: rd_data = '0;
          default:    rd_data = stat_word;
        endcase
      end else if (op_word) begin
        rd_data = ram_word;
      end else if (op_half) begin
        rd_data = op_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end else begin
        rd_data = op_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
    end
  end

  assign dmemdataout = rd_data;

  // ---------------- stores ----------------
  assign st_ok    = dmemwe && !illegal && !halt_q;
  assign ram_we   = st_ok && !is_mmio;
  assign st_be    = op_word ? 4'hF
                  : op_half ? (dmemaddr[1] ? 4'hC : 4'h3)
                  : (4'b0001 << dmemaddr[1:0]);
  // Replicate the low bits so every lane sees the right data; st_be picks.
  assign st_data  = op_word ? dmemdatain
                  : op_half ? {2{dmemdatain[15:0]}}
                  : {4{dmemdatain[7:0]}};

  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) ram_q[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // ---------------- MMIO registers ----------------
  assign push_req = st_ok && is_mmio && (off == OFF_CON_TX);
  assign pop      = con_ready && con_valid;

  always_comb begin
    cycle_d  = halt_q ? cycle_q : cycle_q + 32'd1;
    tohost_d = tohost_q;
    halt_d   = halt_q;
    pass_d   = pass_q;
    err_d    = err_q | illegal;
    ovf_d    = ovf_q | (push_req && fifo_full && !pop);
    if (st_ok && is_mmio && (off == OFF_TOHOST)) begin
      tohost_d = dmemdatain;
      halt_d   = 1'b1;
      pass_d   = (dmemdatain == 32'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      tohost_q <= '0;
      halt_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  con_fifo #(.CON_DEPTH(CON_DEPTH)) u_con_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_req),
    .data_i  (dmemdatain[7:0]),
    .pop_i   (con_ready),
    .data_o  (con_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign con_valid    = !fifo_empty;
  assign halt         = halt_q;
  assign pass         = pass_q;
  assign err          = err_q;
  assign con_overflow = ovf_q;

endmodule

// File: tb/tb_dmem_mmio_resp.sv
// tb/tb_dmem_mmio_resp.sv - self-checking bench for dmem_mmio_resp
module tb_dmem_mmio_resp;

  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100, OP_HU = 3'b101;
  localparam logic [31:0] A_CYCLE = 32'h8000_0000, A_TOHOST = 32'h8000_0004;
  localparam logic [31:0] A_CONTX = 32'h8000_0008, A_STAT = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmemaddr = A_CYCLE, dmemdatain = '0;
  logic [2:0]  dmemop = OP_W;
  logic        dmemwe = 1'b0, con_ready = 1'b0;
  logic [31:0] dmemdataout;
  logic [7:0]  con_data;
  logic        con_valid, halt, pass, err, con_overflow;

  dmem_mmio_resp dut (
    .clk(clk), .rst(rst), .dmemaddr(dmemaddr), .dmemdatain(dmemdatain),
    .dmemop(dmemop), .dmemwe(dmemwe), .dmemdataout(dmemdataout),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .halt(halt), .pass(pass), .err(err), .con_overflow(con_overflow)
  );

  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;

  // Reference model: byte-granular RAM image (low 256 bytes), flags, a queue.
  logic [7:0]  ram_m [256];
  logic [31:0] cyc_m, tohost_m;
  logic        halt_m, pass_m, err_m, ovf_m;
  logic [7:0]  q_m [$];
  logic [31:0] last_rd, cap;
  logic        last_cv;
  logic [7:0]  last_cd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_ill(logic [31:0] a, logic [2:0] op, logic we);
    logic legal_op = (op == OP_B) || (op == OP_H) || (op == OP_W) || (op == OP_BU) || (op == OP_HU);
    logic halfop   = (op == OP_H) || (op == OP_HU);
    if (!legal_op) return 1'b1;
    if (halfop && a[0]) return 1'b1;
    if (op == OP_W && a[1:0] != 2'b00) return 1'b1;
    if (we && (op == OP_BU || op == OP_HU)) return 1'b1;
    if (a[31:28] == 4'h8 && op != OP_W) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] op, logic we);
    logic [7:0]  b = a[7:0];
    logic [15:0] h;
    if (is_ill(a, op, we)) return 32'h0;
    if (a[31:28] == 4'h8) begin
      case (a[3:2])
        2'd0: return cyc_m;
        2'd1: return tohost_m;
        2'd2: return 32'h0;
        default: return {20'h0, 8'(q_m.size()), 2'b00, q_m.size() == 0, q_m.size() == 8};
      endcase
    end
    h = {ram_m[b + 8'd1], ram_m[b]};
    case (op)
      OP_B:    return 32'($signed(ram_m[b]));
      OP_BU:   return {24'h0, ram_m[b]};
      OP_H:    return 32'($signed(h));
      OP_HU:   return {16'h0, h};
      default: return {ram_m[b + 8'd3], ram_m[b + 8'd2], ram_m[b + 8'd1], ram_m[b]};
    endcase
  endfunction

  task automatic model_reset();
    cyc_m = 0; tohost_m = 0; halt_m = 0; pass_m = 0; err_m = 0; ovf_m = 0;
    q_m.delete();
  endtask

  task automatic model_edge();
    logic [7:0] b = dmemaddr[7:0];
    logic push = 1'b0;
    logic halt_new = halt_m;
    if (is_ill(dmemaddr, dmemop, dmemwe)) begin
      err_m = 1'b1;
    end else if (dmemwe && !halt_m) begin
      if (dmemaddr[31:28] == 4'h8) begin
        if (dmemaddr[3:2] == 2'd1) begin
          tohost_m = dmemdatain; pass_m = (dmemdatain == 1); halt_new = 1'b1;
        end else if (dmemaddr[3:2] == 2'd2) begin
          push = 1'b1;
        end
      end else begin
        ram_m[b] = dmemdatain[7:0];
        if (dmemop != OP_B) ram_m[b + 8'd1] = dmemdatain[15:8];
        if (dmemop == OP_W) begin
          ram_m[b + 8'd2] = dmemdatain[23:16];
          ram_m[b + 8'd3] = dmemdatain[31:24];
        end
      end
    end
    if (!halt_m) cyc_m = cyc_m + 1;
    halt_m = halt_new;
    if (con_ready && q_m.size() > 0) void'(q_m.pop_front());
    if (push) begin
      if (q_m.size() < 8) q_m.push_back(dmemdatain[7:0]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic sample();
    chk("dout", dmemdataout, ref_load(dmemaddr, dmemop, dmemwe));
    chk("err", {31'h0, err}, {31'h0, err_m});
    chk("halt", {31'h0, halt}, {31'h0, halt_m});
    chk("pass", {31'h0, pass}, {31'h0, pass_m});
    chk("ovf", {31'h0, con_overflow}, {31'h0, ovf_m});
    chk("valid", {31'h0, con_valid}, {31'h0, q_m.size() != 0});
    if (q_m.size() != 0) chk("cdata", {24'h0, con_data}, {24'h0, q_m[0]});
    last_rd = dmemdataout;
    last_cv = con_valid;
    last_cd = con_data;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                      input logic we, input logic rdy);
    dmemaddr = a; dmemdatain = d; dmemop = op; dmemwe = we; con_ready = rdy;
    @(negedge clk);
    sample();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    dmemaddr = A_CYCLE; dmemdatain = '0; dmemop = OP_W; dmemwe = 1'b0; con_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] lops [5];
    logic [31:0] a;
    logic [2:0]  op;
    logic        we;
    lops = '{OP_B, OP_H, OP_W, OP_BU, OP_HU};

    do_reset();
    for (int i = 0; i < 10; i++) step(A_CYCLE, 0, OP_W, 0, 0);
    step(A_CYCLE, 0, OP_W, 0, 0);
    chk("cyc10", last_rd, 32'd10);

    for (int i = 0; i < 64; i++) step(32'(i * 4), 0, OP_W, 1, 0);

    step(32'h10, 32'h1234_5678, OP_W, 1, 0);
    step(32'h10, 0, OP_W, 0, 0);  chk("lw", last_rd, 32'h1234_5678);
    step(32'h12, 0, OP_H, 0, 0);  chk("lh", last_rd, 32'h0000_1234);
    step(32'h12, 0, OP_HU, 0, 0); chk("lhu", last_rd, 32'h0000_1234);
    step(32'h13, 0, OP_B, 0, 0);  chk("lb", last_rd, 32'h0000_0012);
    step(32'h13, 0, OP_BU, 0, 0); chk("lbu", last_rd, 32'h0000_0012);
    step(32'h11, 32'hF0, OP_B, 1, 0);
    step(32'h10, 0, OP_W, 0, 0);  chk("lw_sb", last_rd, 32'h1234_F078);
    step(32'h11, 0, OP_B, 0, 0);  chk("lb_neg", last_rd, 32'hFFFF_FFF0);

    step(32'h11, 0, OP_H, 0, 0);  chk("lh_mis", last_rd, 32'h0);
    chk("err_next", {31'h0, err}, 32'd1);
    step(32'h22, 32'hDEAD_BEEF, OP_W, 1, 0);
    step(32'h20, 0, OP_W, 0, 0);  chk("sw_mis", last_rd, 32'h0);
    do_reset();
    chk("err_rst", {31'h0, err}, 32'd0);

    for (int i = 0; i < 9; i++) step(A_CONTX, 32'h41 + 32'(i), OP_W, 1, 0);
    step(A_STAT, 0, OP_W, 0, 0);
    chk("stat_full", last_rd, 32'h81);
    chk("ovf_set", {31'h0, con_overflow}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(A_CYCLE, 0, OP_W, 0, 1);
      chk("drain", {23'h0, last_cv, last_cd}, {23'h1, 8'h41 + 8'(i)});
    end
    step(A_CYCLE, 0, OP_W, 0, 0);
    chk("drained", {31'h0, last_cv}, 32'd0);

    do_reset();
    for (int i = 0; i < 8; i++) step(A_CONTX, 32'h30 + 32'(i), OP_W, 1, 0);
    step(A_CONTX, 32'h5A, OP_W, 1, 1);
    step(A_STAT, 0, OP_W, 0, 0);
    chk("stat_pp", last_rd, 32'h81);
    chk("ovf_pp", {31'h0, con_overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(A_CYCLE, 0, OP_W, 0, 1);
      chk("drain_pp", {24'h0, last_cd}, (i == 7) ? 32'h5A : 32'h31 + 32'(i));
    end

    do_reset();
    step(A_TOHOST, 1, OP_W, 1, 0);
    chk("halt1", {30'h0, halt, pass}, 32'd3);
    cap = cyc_m;
    step(A_CYCLE, 0, OP_W, 0, 0);
    step(A_CYCLE, 0, OP_W, 0, 0); chk("cyc_frz", last_rd, cap);
    step(32'h40, 32'hA5A5_A5A5, OP_W, 1, 0);
    step(32'h40, 0, OP_W, 0, 0);  chk("halt_st", last_rd, 32'h0);
    step(A_CONTX, 32'h51, OP_W, 1, 0);
    chk("halt_push", {31'h0, con_valid}, 32'd0);

    do_reset();
    step(A_TOHOST, 5, OP_W, 1, 0);
    step(A_TOHOST, 0, OP_W, 0, 0); chk("tohost5", last_rd, 32'd5);
    chk("halt5", {30'h0, halt, pass}, 32'd2);
    step(A_TOHOST, 1, OP_W, 1, 0);
    step(A_TOHOST, 0, OP_W, 0, 0); chk("tohost2", last_rd, 32'd5);
    chk("pass2", {31'h0, pass}, 32'd0);

    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        a  = 32'h8000_0000 | ($urandom & 32'h0FFF_FFF0) | (32'($urandom_range(0, 3)) << 2);
        op = ($urandom_range(0, 7) == 0) ? lops[$urandom_range(0, 4)] : OP_W;
        we = (a[3:2] == 2'd1) ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        op = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : lops[$urandom_range(0, 4)];
        a  = ($urandom & 32'h0FFF_0000) | 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) != 0) begin
          if (op == OP_W) a[1:0] = 2'b00;
          else if (op == OP_H || op == OP_HU) a[0] = 1'b0;
        end
        we = 1'($urandom_range(0, 1));
      end
      step(a, $urandom, op, we, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
